// File: rtl/ram_fifo_pkg.sv
// Shared constants and encodings for the stream-to-RAM FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DEPTH  = 64;

    // Round-robin owner of the next contested RAM access.
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream, RAM-pin and status bundle of the RAM FIFO controller.
// master: upstream/downstream/RAM environment; slave: the controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = ram_fifo_pkg::DEF_DATA_W,
    parameter int ADDR_W = ram_fifo_pkg::DEF_ADDR_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output in_data, in_valid, out_ready, ram_q,
        input  in_ready, out_data, out_valid, ram_we, ram_wr_addr,
               ram_rd_addr, ram_data, count, full, empty
    );

    modport slave (
        input  in_data, in_valid, out_ready, ram_q,
        output in_ready, out_data, out_valid, ram_we, ram_wr_addr,
               ram_rd_addr, ram_data, count, full, empty
    );

endinterface

// File: rtl/ram_fifo_out_buf.sv
// Two-entry registered output buffer. The head entry drives out_data directly,
// so the output only moves on a pop or on a push into an empty buffer.
module ram_fifo_out_buf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        buf_cnt
);

    logic [DATA_W-1:0] tail_q;
    logic              pop_ok;
    logic [1:0]        cnt_nxt;

    assign pop_ok = pop & out_valid;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        cnt_nxt = buf_cnt;
        if (push && !pop_ok)
            cnt_nxt = buf_cnt + 2'd1;
        else if (!push && pop_ok)
            cnt_nxt = buf_cnt - 2'd1;
    end

    // Head/tail data movement and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
            buf_cnt   <= 2'd0;
        end else begin
            buf_cnt   <= cnt_nxt;
            out_valid <= (cnt_nxt != 2'd0);
            if (pop_ok) begin
                if (buf_cnt == 2'd2) begin
                    out_data <= tail_q;
                    if (push)
                        tail_q <= push_data;
                end else if (push) begin
                    out_data <= push_data;
                end
            end else if (push) begin
                if (buf_cnt == 2'd0)
                    out_data <= push_data;
                else
                    tail_q <= push_data;
            end
        end
    end

    // The upstream read credit must never let a third word arrive.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_ok && buf_cnt == 2'd2));

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller: owns the single RAM port, arbitrating one
// write or one read per cycle, and hides the RAM read latency behind a
// 2-entry output buffer.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              rd_pend;
    prio_t             prio;
    logic [1:0]        buf_cnt;

    logic       full_w;
    logic       empty_w;
    logic       out_fire;
    logic [2:0] buf_credit;
    logic       rd_want;
    logic       wr_pend;
    logic       in_ready_w;
    logic       wr_fire;
    logic       rd_fire;
    logic       contested;

    assign full_w   = (count_q == FULL_CNT);
    assign empty_w  = (count_q == '0);
    assign out_fire = bus.out_valid & bus.out_ready;

    // Buffer slots already spoken for: held words plus a read in flight,
    // minus the word leaving this cycle. A read is only issued if a slot remains.
    assign buf_credit = 3'(buf_cnt) + 3'(rd_pend) - 3'(out_fire);
    assign rd_want    = !empty_w && (buf_credit < 3'd2);

    assign wr_pend    = bus.in_valid & !full_w;
    assign in_ready_w = !rst && !full_w && !(rd_want && (prio == PRIO_RD));
    assign wr_fire    = bus.in_valid & in_ready_w;
    assign rd_fire    = rd_want & !wr_fire;
    assign contested  = rd_want & wr_pend;

    assign bus.in_ready    = in_ready_w;
    assign bus.ram_we      = wr_fire;
    assign bus.ram_wr_addr = wr_ptr;
    assign bus.ram_rd_addr = rd_ptr;
    assign bus.ram_data    = bus.in_data;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;

    // Pointers wrap silently; count separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_fire)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_fire)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_fire)
                count_q <= count_q + (ADDR_W+1)'(1);
            else if (rd_fire)
                count_q <= count_q - (ADDR_W+1)'(1);
        end
    end

    // Round-robin arbiter state and the read-in-flight marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= PRIO_WR;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_fire;
            if (contested)
                prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
        end
    end

    ram_fifo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (bus.ram_q),
        .pop       (out_fire),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .buf_cnt   (buf_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 64x8 RAM attached.
module tb_ram_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port RAM: write when we, otherwise registered read.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_wr_addr] <= bus.ram_data;
        else
            bus.ram_q <= mem[bus.ram_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input bit ok, input string name,
                                input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: an ordered queue of accepted words plus a write tally.
    logic [7:0] exp_q [$];
    int         wr_total;
    bit         have_prev;
    bit         prev_stall;
    bit         prev_empty;
    logic [7:0] prev_data;
    logic [5:0] prev_rd_addr;
    int         prev_count;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wr_total  = 0;
            have_prev = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                chk(bus.ram_we == 1'b1, "ram_we_on_accept", bus.ram_we, 1);
                chk(bus.ram_wr_addr == 6'(wr_total), "ram_wr_addr", bus.ram_wr_addr, wr_total % 64);
                chk(bus.ram_data == bus.in_data, "ram_data", bus.ram_data, bus.in_data);
                exp_q.push_back(bus.in_data);
                wr_total++;
            end else begin
                chk(bus.ram_we == 1'b0, "ram_we_idle", bus.ram_we, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk(exp_q.size() != 0, "unexpected_output", bus.out_data, -1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(bus.out_data == e, "out_data_order", bus.out_data, e);
                end
            end
            if (have_prev) begin
                if (prev_stall) begin
                    chk(bus.out_valid == 1'b1, "stall_valid", bus.out_valid, 1);
                    chk(bus.out_data == prev_data, "stall_data", bus.out_data, prev_data);
                end
                if (prev_empty)
                    chk(bus.ram_rd_addr == prev_rd_addr, "no_read_when_empty", bus.ram_rd_addr, prev_rd_addr);
                chk((int'(bus.count) - prev_count) <= 1 && (prev_count - int'(bus.count)) <= 1,
                    "count_step", bus.count, prev_count);
            end
            chk(bus.count <= 7'd64, "count_range", bus.count, 64);
            chk(bus.full == (bus.count == 7'd64), "full_flag", bus.full, bus.count == 7'd64);
            chk(bus.empty == (bus.count == 7'd0), "empty_flag", bus.empty, bus.count == 7'd0);
            prev_stall   = bus.out_valid && !bus.out_ready;
            prev_empty   = bus.empty;
            prev_data    = bus.out_data;
            prev_rd_addr = bus.ram_rd_addr;
            prev_count   = int'(bus.count);
            have_prev    = 1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [7:0] d);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk(ok, "send_accept", ok, 1);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid || !bus.empty) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 1000, "drain_done", n, 1000);
        @(negedge clk);
        chk(bus.count == 7'd0, "drain_count", bus.count, 0);
        chk(bus.empty == 1'b1, "drain_empty", bus.empty, 1);
        chk(exp_q.size() == 0, "drain_scoreboard", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         sent;
        int         cyc;
        logic [7:0] d;
        logic       prev_we;

        // Reset values, with in_valid high to show in_ready ignores it.
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(bus.in_ready == 1'b0, "rst_in_ready", bus.in_ready, 0);
        chk(bus.ram_we == 1'b0, "rst_ram_we", bus.ram_we, 0);
        chk(bus.empty == 1'b1, "rst_empty", bus.empty, 1);
        chk(bus.full == 1'b0, "rst_full", bus.full, 0);
        chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
        chk(bus.out_data == 8'h00, "rst_out_data", bus.out_data, 0);
        chk(bus.count == 7'd0, "rst_count", bus.count, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Single word latency, then two back-to-back words.
        bus.out_ready = 1'b1;
        send(8'h11);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk(bus.out_valid == (k == 3), "latency_valid", bus.out_valid, k == 3);
        end
        chk(bus.out_data == 8'h11, "latency_data", bus.out_data, 8'h11);
        @(posedge clk); #1;
        send(8'h22);
        send(8'h33);
        drain();

        // Fill to full with the output stalled, then release.
        do_reset();
        for (int i = 0; i < 66; i++)
            send(8'(i));
        @(negedge clk);
        chk(bus.count == 7'd64, "fill_count", bus.count, 64);
        chk(bus.full == 1'b1, "fill_full", bus.full, 1);
        chk(bus.in_ready == 1'b0, "fill_in_ready", bus.in_ready, 0);
        chk(bus.out_valid == 1'b1, "fill_out_valid", bus.out_valid, 1);
        chk(bus.out_data == 8'h00, "fill_head", bus.out_data, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk(bus.in_ready == 1'b0, "full_first_read_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "full_recover_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        drain();

        // Continuous writes and reads: grants alternate once contested.
        do_reset();
        bus.out_ready = 1'b1;
        d       = 8'h80;
        sent    = 0;
        cyc     = 0;
        prev_we = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (sent < 40 && cyc < 400) begin
            @(negedge clk);
            if (cyc >= 2)
                chk(bus.ram_we != prev_we, "grant_alternate", bus.ram_we, !prev_we);
            if (cyc >= 1)
                chk(bus.count >= 7'd1 && bus.count <= 7'd2, "contested_count", bus.count, 2);
            prev_we = bus.ram_we;
            if (bus.in_ready) begin
                sent++;
                d = d + 8'd1;
            end
            @(posedge clk); #1;
            bus.in_data = d;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk(sent == 40, "stream_sent", sent, 40);
        drain();

        // Random traffic with output stalls, wrapping the pointers.
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 5000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk(sent == 200, "random_sent", sent, 200);
        chk(wr_total == 200, "random_wr_total", wr_total, 200);
        drain();

        // Reset while a read is in flight with 10 words stored.
        do_reset();
        for (int i = 0; i < 12; i++)
            send(8'(8'h40 + i));
        @(negedge clk);
        chk(bus.count == 7'd10, "pre_reset_count", bus.count, 10);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk(bus.out_valid == 1'b0, "midrst_out_valid", bus.out_valid, 0);
        chk(bus.count == 7'd0, "midrst_count", bus.count, 0);
        chk(bus.empty == 1'b1, "midrst_empty", bus.empty, 1);
        chk(bus.in_ready == 1'b0, "midrst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(8'hAB);
        cyc = 0;
        while (!bus.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk(bus.out_valid == 1'b1, "post_rst_valid", bus.out_valid, 1);
        chk(bus.out_data == 8'hAB, "post_rst_data", bus.out_data, 8'hAB);
        @(posedge clk); #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
